maquina_lectura: RTL
====================

# maquina_lectura

Read-side counterpart of the RTC write state machine. It drives the RTC's multiplexed address/data parallel bus (CS, WR, RD, AD, 8-bit shared bus) to read the six time/date registers in sequence: seconds, minutes, hours, day, month, year. Each value is captured into a shadow buffer. All six outputs are committed together, so the rest of the design (display/formatting logic) sees a coherent snapshot. It sits beside the write machine behind the bus arbiter; only one of the two owns the bus at a time.

## Interface
Parameters:
- T_FASE, 10: cycles per bus phase; legal range 1..255; 10 gives 100 ns per phase at 100 MHz.
- DIR_SEG, 8'h21: RTC address for seconds.
- DIR_MIN, 8'h22: RTC address for minutes.
- DIR_HORA, 8'h23: RTC address for hours.
- DIR_DIA, 8'h24: RTC address for day.
- DIR_MES, 8'h25: RTC address for month.
- DIR_ANO, 8'h26: RTC address for year.

Ports:
- clk, in, 1: system clock; single clock domain.
- reset, in, 1: asynchronous, active-high reset.
- Lectura, in, 1: start request; level-sensitive.
- Dato_in, in, 8: bus value driven by the RTC.
- Dato_Dire, out, 8: address driven onto the bus.
- Dir_Oe, out, 1: 1 = this block drives the bus with Dato_Dire; 0 = bus released.
- CS, out, 1: chip select, active low.
- WR, out, 1: write strobe, active low.
- RD, out, 1: read strobe, active low.
- AD, out, 1: 0 = address phase, 1 = data phase.
- Seg, Min, Hora, Dia, Mes, Ano, out, 8 each: committed register values.
- Term_Lect, out, 1: one-cycle pulse when a full read completes.

## Operation
- States: IDLE, A_SET, A_WR, A_HLD, D_SET, D_RD, D_HLD, DONE, ESPERA.
- Every state from A_SET through D_HLD lasts exactly T_FASE cycles. An 8-bit phase counter times each state.
- A 3-bit index (0..5) selects the register, in the order Seg, Min, Hora, Dia, Mes, Ano.

Output values by state:
- IDLE: CS=1, WR=1, RD=1, AD=1, Dir_Oe=0.
- A_SET: AD=0, Dir_Oe=1, Dato_Dire=address[index]; CS=1, WR=1, RD=1.
- A_WR: CS=0, WR=0, AD=0, Dir_Oe=1; address held.
- A_HLD: CS=1, WR=1, AD=0, Dir_Oe=1; address held.
- D_SET: AD=1, Dir_Oe=0, CS=1, RD=1.
- D_RD: CS=0, RD=0, AD=1, Dir_Oe=0. Dato_in is sampled into shadow[index] on the clock edge that ends D_RD (last cycle of the phase).
- D_HLD: CS=1, RD=1, AD=1. At its end:
  - index < 5: increment index, go to A_SET.
  - index = 5: go to DONE.

Control transitions:
- IDLE -> A_SET when Lectura=1 is sampled in IDLE.
- DONE lasts 1 cycle: Term_Lect=1; all six outputs are loaded from the shadow buffer on the edge entering DONE. Then go to ESPERA.
- ESPERA: holds until Lectura=0, then goes to IDLE. A held-high Lectura never retriggers.

Invariants:
- WR and RD are never low in the same cycle.
- Dir_Oe=1 only while AD=0.
- WR stays 1 outside A_WR; RD stays 1 outside D_RD.
- The Seg..Ano outputs change only on entry to DONE. Partial reads are never visible.

## Timing
- Reset values: CS=WR=RD=AD=1, Dir_Oe=0, Dato_Dire=8'h00, Term_Lect=0, Seg..Ano=8'h00, shadow=0, index=0, state=IDLE.
- Latency: Lectura sampled high at edge k. A_SET begins in cycle k+1. Term_Lect is high in cycle k+36·T_FASE+1 (T_FASE=10 gives 361 cycles).
- Per-register transaction: 6·T_FASE cycles. CS low-pulse width: T_FASE. Address setup/hold around WR: T_FASE each.
- Lectura dropping mid-transaction is ignored; the transaction runs to completion.
- Reset mid-transaction aborts immediately:
  - strobes return high and the bus is released;
  - outputs and shadow are cleared;
  - the next start requires Lectura to be sampled high in IDLE after reset is released.
- T_FASE=1 is legal: each phase is 1 cycle, 37 cycles to Term_Lect.

## Test plan
- Reset: hold reset 100 ns mid-operation -> CS=WR=RD=AD=1, Dir_Oe=0, all outputs 0 within the same cycle (asynchronous); no strobe glitch after release.
- Nominal read (T_FASE=10):
  - Stimulus: RTC model returns 8'h45, 8'h34, 8'h03, 8'h08, 8'h09, 8'h16 for addresses 21..26; Lectura pulse.
  - Required: Term_Lect at cycle 361; outputs equal those values; observed address order 21, 22, 23, 24, 25, 26 on WR falling.
- Protocol check: a monitor asserts WR/RD never simultaneously low, Dir_Oe=0 whenever RD=0, and CS low width = 10 cycles each, 12 pulses per read.
- Level hold: Lectura held high 2000 ns past completion -> exactly one Term_Lect. Dropping then re-raising Lectura -> second read; changed RTC values appear only at the second Term_Lect.
- Snapshot coherence: RTC model changes the seconds value during the hours read -> Seg..Ano keep their old values until DONE, then all update in the same cycle.
- Minimum phase: T_FASE=1 -> Term_Lect at cycle 37 with correct data.

Source files
------------

// File: rtl/maquina_lectura.sv
// Read sequencer for the RTC multiplexed address/data bus: fetches seconds..year
// into a shadow buffer and commits all six values together on completion.
//
// state  | meaning
// IDLE   | bus released, waiting for Lectura
// A_SET  | address driven, AD=0, strobes high (address setup)
// A_WR   | address latched by the RTC: CS and WR low
// A_HLD  | address still driven after WR rises (address hold)
// D_SET  | bus released, AD=1, waiting before the read strobe
// D_RD   | CS and RD low; RTC data sampled on the last cycle
// D_HLD  | strobes high; advance index or finish
// DONE   | one-cycle Term_Lect; snapshot just committed
// ESPERA | waits for Lectura to drop before re-arming
module maquina_lectura #(
  parameter int unsigned T_FASE   = 10,
  parameter logic [7:0]  DIR_SEG  = 8'h21,
  parameter logic [7:0]  DIR_MIN  = 8'h22,
  parameter logic [7:0]  DIR_HORA = 8'h23,
  parameter logic [7:0]  DIR_DIA  = 8'h24,
  parameter logic [7:0]  DIR_MES  = 8'h25,
  parameter logic [7:0]  DIR_ANO  = 8'h26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Lectura,
  input  logic [7:0] Dato_in,
  output logic [7:0] Dato_Dire,
  output logic       Dir_Oe,
  output logic       CS,
  output logic       WR,
  output logic       RD,
  output logic       AD,
  output logic [7:0] Seg,
  output logic [7:0] Min,
  output logic [7:0] Hora,
  output logic [7:0] Dia,
  output logic [7:0] Mes,
  output logic [7:0] Ano,
  output logic       Term_Lect
);

  typedef enum logic [3:0] {
    IDLE, A_SET, A_WR, A_HLD, D_SET, D_RD, D_HLD, DONE, ESPERA
  } estado_t;

  localparam logic [7:0] CNT_INI = 8'(T_FASE - 1);

  estado_t    estado_q, estado_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] shadow_q [6];
  logic [7:0] salida_q [6];
  logic       en_fase, fin_fase, cap_en, commit_en;
  logic [7:0] dir_sel;

  assign en_fase  = (estado_q inside {A_SET, A_WR, A_HLD, D_SET, D_RD, D_HLD});
  assign fin_fase = (cnt_q == 8'd0);

  always_comb begin
    dir_sel = DIR_ANO;
    case (idx_q)
      3'd0:    dir_sel = DIR_SEG;
      3'd1:    dir_sel = DIR_MIN;
      3'd2:    dir_sel = DIR_HORA;
      3'd3:    dir_sel = DIR_DIA;
      3'd4:    dir_sel = DIR_MES;
      default: dir_sel = DIR_ANO;
    endcase
  end

  always_comb begin
    estado_d  = estado_q;
    idx_d     = idx_q;
    cap_en    = 1'b0;
    commit_en = 1'b0;
    case (estado_q)
      IDLE:   if (Lectura) estado_d = A_SET;
      A_SET:  if (fin_fase) estado_d = A_WR;
      A_WR:   if (fin_fase) estado_d = A_HLD;
      A_HLD:  if (fin_fase) estado_d = D_SET;
      D_SET:  if (fin_fase) estado_d = D_RD;
      D_RD: begin
        if (fin_fase) begin
          cap_en   = 1'b1;
          estado_d = D_HLD;
        end
      end
      D_HLD: begin
        if (fin_fase) begin
          if (idx_q == 3'd5) begin
            idx_d     = 3'd0;
            commit_en = 1'b1;
            estado_d  = DONE;
          end else begin
            idx_d    = idx_q + 3'd1;
            estado_d = A_SET;
          end
        end
      end
      DONE:   estado_d = ESPERA;
      ESPERA: if (!Lectura) estado_d = IDLE;
      default: estado_d = IDLE;
    endcase

    // Counter reloads on every phase boundary so each phase is exactly T_FASE cycles.
    if (en_fase) cnt_d = fin_fase ? CNT_INI : cnt_q - 8'd1;
    else         cnt_d = CNT_INI;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q <= IDLE;
      cnt_q    <= CNT_INI;
      idx_q    <= 3'd0;
    end else begin
      estado_q <= estado_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 6; i++) begin
        shadow_q[i] <= 8'h00;
        salida_q[i] <= 8'h00;
      end
    end else begin
      for (int i = 0; i < 6; i++) begin
        if (cap_en && idx_q == 3'(i)) shadow_q[i] <= Dato_in;
        if (commit_en)                salida_q[i] <= shadow_q[i];
      end
    end
  end

  // Strobes decode straight from the state register so reset releases the bus at once.
  always_comb begin
    CS        = 1'b1;
    WR        = 1'b1;
    RD        = 1'b1;
    AD        = 1'b1;
    Dir_Oe    = 1'b0;
    Dato_Dire = 8'h00;
    Term_Lect = 1'b0;
    case (estado_q)
      A_SET, A_HLD: begin
        AD        = 1'b0;
        Dir_Oe    = 1'b1;
        Dato_Dire = dir_sel;
      end
      A_WR: begin
        CS        = 1'b0;
        WR        = 1'b0;
        AD        = 1'b0;
        Dir_Oe    = 1'b1;
        Dato_Dire = dir_sel;
      end
      D_RD: begin
        CS = 1'b0;
        RD = 1'b0;
      end
      DONE:    Term_Lect = 1'b1;
      default: ;
    endcase
  end

  assign Seg  = salida_q[0];
  assign Min  = salida_q[1];
  assign Hora = salida_q[2];
  assign Dia  = salida_q[3];
  assign Mes  = salida_q[4];
  assign Ano  = salida_q[5];

endmodule
